mips_cpu_control_fsm: RTL and testbench
=======================================

Name: mips_cpu_control_fsm

Overview:
- Multi-cycle sequencer for the MIPS CPU datapath.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Drives the register file's write strobe and write index.
- Drives the memory bus strobes and the PC/IR load enables.
- Halts the CPU on a jump to address 0.

Parameters:
STALL_LIMIT, 0, max consecutive waitrequest cycles tolerated in FETCH/MEM; 0 = unlimited
CNT_W, 8, width of the stall counter; STALL_LIMIT must fit in CNT_W bits

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
instr_opcode  in  6  IR[31:26]
instr_funct  in  6  IR[5:0]
instr_rt  in  5  IR[20:16]
instr_rd  in  5  IR[15:11]
alu_zero  in  1  ALU equality flag, valid in EXEC
pc_next_zero  in  1  jump target == 0, valid in EXEC
mem_waitrequest  in  1  memory not ready; the request must be held
mem_read  out  1  memory read strobe
mem_write  out  1  memory write strobe
addr_sel_pc  out  1  1 = address from PC, 0 = from ALU result
ir_write  out  1  load the instruction register
pc_write  out  1  load PC from pc_src
pc_src  out  2  0 = PC+4, 1 = branch target, 2 = jump target, 3 = rs register
reg_write  out  1  register-file write enable (Regwrite)
write_register  out  5  register-file write index
mem_to_reg  out  1  write data comes from memory
alu_src_imm  out  1  ALU operand B is the sign-extended immediate
active  out  1  high while the CPU runs
error  out  1  sticky fault flag
state  out  3  current state, for debug

Behaviour:
- Encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- Outputs are decoded from the state.
- While reset is high, every output is 0 and the registers load state=FETCH, error=0, stall count=0.
- First cycle after reset deasserts: FETCH with active=1.
- A reset asserted mid-instruction (any state, including HALT) aborts the instruction. No partial write occurs.
- FETCH:
  - mem_read=1, addr_sel_pc=1.
  - While waitrequest is high, hold all strobes and stay in FETCH.
  - On the cycle waitrequest is low: ir_write=1, pc_write=1, pc_src=0, then go to DECODE.
- DECODE: no strobes; one cycle; register operands settle; go to EXEC.
- EXEC, by class:
  - R-type (op 0x00, funct not 0x08) and ADDIU (0x09): go to WB. alu_src_imm=1 for ADDIU.
  - LW (0x23) and SW (0x2B): alu_src_imm=1, go to MEM.
  - BEQ (0x04): pc_write=alu_zero, pc_src=1, go to FETCH.
  - J (0x02): pc_write=1, pc_src=2, go to FETCH.
  - JR (op 0x00, funct 0x08): pc_write=1, pc_src=3. Go to HALT if pc_next_zero, else FETCH.
  - Any other opcode: treated as NOP, go to FETCH (see Optional Feature).
- MEM:
  - addr_sel_pc=0; mem_read=1 for LW, mem_write=1 for SW.
  - Held while waitrequest is high.
  - On acceptance: SW goes to FETCH, LW goes to WB.
- WB:
  - write_register = instr_rd for R-type, instr_rt for ADDIU/LW.
  - mem_to_reg=1 for LW.
  - reg_write=1 for exactly one cycle, then go to FETCH.
  - If write_register==0, reg_write is forced to 0. The register file stores writes to index 0, so the controller guarantees $zero is never written.
- HALT: active=0, all strobes 0. Stays until reset.
- Stall counter:
  - Increments each cycle waitrequest is high in FETCH/MEM; clears when a request is accepted.
  - If STALL_LIMIT!=0 and the count reaches STALL_LIMIT: go to HALT with error=1, drop strobes.
- Latency: R-type/ADDIU 4 cycles, LW 5, SW 4, branch/jump 3, each plus any wait cycles.

Optional Feature:
- ILLEGAL_OPCODE_HALT_EN defined: an unrecognised opcode, or an op 0x00 funct outside the supported set, sends EXEC to HALT with error=1, no PC/reg writes.
- Undefined: such instructions are NOPs and error only reflects stall timeouts.

Decomposition:
- Package mips_cpu_pkg holds:
  - state_t enum
  - opcode constants (OP_RTYPE, OP_ADDIU, OP_LW, OP_SW, OP_BEQ, OP_J)
  - FUNCT_JR
  - pc_src_t enum
- One natural sub-module, mips_cpu_instr_class: combinational opcode/funct to class decode.
- The FSM and stall counter stay in the top module.

Test Plan:
- ADDIU rt=8 with no waits → FETCH,DECODE,EXEC,WB; reg_write high exactly in cycle 4, write_register=8, alu_src_imm=1.
- LW rt=2 with 3 waitrequest cycles in MEM → mem_read held 4 cycles, mem_write=0; then WB with mem_to_reg=1, write_register=2.
- R-type with rd=0 → WB state reached with reg_write=0; BEQ with alu_zero=0 → pc_write=0, returns to FETCH.
- JR with pc_next_zero=1 → pc_write=1, pc_src=3, then HALT with active=0; further cycles show no strobes; reset returns to FETCH.
- STALL_LIMIT=4, waitrequest stuck high in FETCH → HALT with error=1 after 4 cycles.
- Reset pulsed during MEM of SW → mem_write drops the same cycle; FETCH follows.
- Opcode 0x3F → FETCH with error=0 when ILLEGAL_OPCODE_HALT_EN is undefined; HALT with error=1 when it is defined.

Source files
------------

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and opcode constants for the MIPS CPU control path
package mips_cpu_pkg;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        PC_SRC_PLUS4  = 2'd0,
        PC_SRC_BRANCH = 2'd1,
        PC_SRC_JUMP   = 2'd2,
        PC_SRC_RS     = 2'd3
    } pc_src_t;

    typedef enum logic [2:0] {
        CLS_RTYPE = 3'd0,
        CLS_ADDIU = 3'd1,
        CLS_LW    = 3'd2,
        CLS_SW    = 3'd3,
        CLS_BEQ   = 3'd4,
        CLS_J     = 3'd5,
        CLS_JR    = 3'd6,
        CLS_OTHER = 3'd7
    } instr_class_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FUNCT_JR = 6'h08;

    // ALU functions the datapath implements for op 0x00 (JR handled separately)
    function automatic logic funct_supported(input logic [5:0] funct);
        case (funct)
            6'h00, 6'h02, 6'h03, 6'h21, 6'h23,
            6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B: funct_supported = 1'b1;
            default:                                   funct_supported = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mips_cpu_instr_class.sv
// rtl/mips_cpu_instr_class.sv - combinational opcode/funct to instruction class decode
module mips_cpu_instr_class
    import mips_cpu_pkg::*;
#(
    parameter bit STRICT_FUNCT = 1'b0
) (
    input  logic [5:0]   opcode,
    input  logic [5:0]   funct,
    output instr_class_t instr_class
);

    always_comb begin
        instr_class = CLS_OTHER;
        case (opcode)
            OP_RTYPE: begin
                if (funct == FUNCT_JR)
                    instr_class = CLS_JR;
                else if (STRICT_FUNCT && !funct_supported(funct))
                    instr_class = CLS_OTHER;
                else
                    instr_class = CLS_RTYPE;
            end
            OP_ADDIU: instr_class = CLS_ADDIU;
            OP_LW:    instr_class = CLS_LW;
            OP_SW:    instr_class = CLS_SW;
            OP_BEQ:   instr_class = CLS_BEQ;
            OP_J:     instr_class = CLS_J;
            default:  instr_class = CLS_OTHER;
        endcase
    end

endmodule

// File: rtl/mips_cpu_control_fsm.sv
// rtl/mips_cpu_control_fsm.sv - multi-cycle sequencer for the MIPS datapath
// ILLEGAL_OPCODE_HALT_EN: unknown opcodes/functs halt with error instead of acting as NOPs.
module mips_cpu_control_fsm
    import mips_cpu_pkg::*;
#(
    parameter int STALL_LIMIT = 0,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] instr_opcode,
    input  logic [5:0] instr_funct,
    input  logic [4:0] instr_rt,
    input  logic [4:0] instr_rd,
    input  logic       alu_zero,
    input  logic       pc_next_zero,
    input  logic       mem_waitrequest,
    output logic       mem_read,
    output logic       mem_write,
    output logic       addr_sel_pc,
    output logic       ir_write,
    output logic       pc_write,
    output logic [1:0] pc_src,
    output logic       reg_write,
    output logic [4:0] write_register,
    output logic       mem_to_reg,
    output logic       alu_src_imm,
    output logic       active,
    output logic       error,
    output logic [2:0] state
);

`ifdef ILLEGAL_OPCODE_HALT_EN
    localparam bit ILLEGAL_HALT = 1'b1;
`else
    localparam bit ILLEGAL_HALT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LIMIT_V = CNT_W'(STALL_LIMIT);

    state_t             state_q, state_d;
    logic               error_q, error_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   stall_inc;
    logic               stall_hit;
    instr_class_t       instr_class;
    pc_src_t            pc_src_sel;

    mips_cpu_instr_class #(
        .STRICT_FUNCT (ILLEGAL_HALT)
    ) u_instr_class (
        .opcode      (instr_opcode),
        .funct       (instr_funct),
        .instr_class (instr_class)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_FETCH;
            error_q     <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            error_q     <= error_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_inc = stall_cnt_q + CNT_W'(1);
    assign stall_hit = (LIMIT_V != '0) && (stall_inc == LIMIT_V);

    always_comb begin
        state_d        = state_q;
        error_d        = error_q;
        stall_cnt_d    = '0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        addr_sel_pc    = 1'b0;
        ir_write       = 1'b0;
        pc_write       = 1'b0;
        pc_src_sel     = PC_SRC_PLUS4;
        reg_write      = 1'b0;
        write_register = 5'd0;
        mem_to_reg     = 1'b0;
        alu_src_imm    = 1'b0;
        active         = 1'b0;

        // Reset gates every output combinationally so an in-flight access drops at once
        if (!reset) begin
            case (state_q)
                ST_FETCH: begin
                    active      = 1'b1;
                    mem_read    = 1'b1;
                    addr_sel_pc = 1'b1;
                    if (mem_waitrequest) begin
                        stall_cnt_d = stall_inc;
                        if (stall_hit) begin
                            state_d = ST_HALT;
                            error_d = 1'b1;
                        end
                    end else begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    active  = 1'b1;
                    state_d = ST_EXEC;
                end
                ST_EXEC: begin
                    active  = 1'b1;
                    state_d = ST_FETCH;
                    case (instr_class)
                        CLS_RTYPE: state_d = ST_WB;
                        CLS_ADDIU: begin
                            alu_src_imm = 1'b1;
                            state_d     = ST_WB;
                        end
                        CLS_LW, CLS_SW: begin
                            alu_src_imm = 1'b1;
                            state_d     = ST_MEM;
                        end
                        CLS_BEQ: begin
                            pc_write   = alu_zero;
                            pc_src_sel = PC_SRC_BRANCH;
                        end
                        CLS_J: begin
                            pc_write   = 1'b1;
                            pc_src_sel = PC_SRC_JUMP;
                        end
                        CLS_JR: begin
                            pc_write   = 1'b1;
                            pc_src_sel = PC_SRC_RS;
                            if (pc_next_zero)
                                state_d = ST_HALT;
                        end
                        default: begin
                            if (ILLEGAL_HALT) begin
                                state_d = ST_HALT;
                                error_d = 1'b1;
                            end
                        end
                    endcase
                end
                ST_MEM: begin
                    active    = 1'b1;
                    mem_read  = (instr_class == CLS_LW);
                    mem_write = (instr_class == CLS_SW);
                    if (mem_waitrequest) begin
                        stall_cnt_d = stall_inc;
                        if (stall_hit) begin
                            state_d = ST_HALT;
                            error_d = 1'b1;
                        end
                    end else begin
                        state_d = (instr_class == CLS_LW) ? ST_WB : ST_FETCH;
                    end
                end
                ST_WB: begin
                    active         = 1'b1;
                    write_register = (instr_class == CLS_RTYPE) ? instr_rd : instr_rt;
                    // $zero is writable in the register file, so suppress the strobe here
                    reg_write      = (write_register != 5'd0);
                    mem_to_reg     = (instr_class == CLS_LW);
                    state_d        = ST_FETCH;
                end
                ST_HALT: state_d = ST_HALT;
                default: state_d = ST_FETCH;
            endcase
        end
    end

    assign pc_src = pc_src_sel;
    assign error  = error_q & ~reset;
    assign state  = reset ? 3'd0 : state_q;

endmodule

// File: tb/tb_mips_cpu_control_fsm.sv
// tb/tb_mips_cpu_control_fsm.sv - table-driven check of the MIPS control sequencer
module tb_mips_cpu_control_fsm;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] instr_opcode, instr_funct;
    logic [4:0] instr_rt, instr_rd;
    logic       alu_zero, pc_next_zero, mem_waitrequest;

    logic       mem_read, mem_write, addr_sel_pc, ir_write, pc_write;
    logic [1:0] pc_src;
    logic       reg_write;
    logic [4:0] write_register;
    logic       mem_to_reg, alu_src_imm, active, error;
    logic [2:0] state;

    logic       d2_mem_read, d2_mem_write, d2_addr_sel_pc, d2_ir_write, d2_pc_write;
    logic [1:0] d2_pc_src;
    logic       d2_reg_write;
    logic [4:0] d2_write_register;
    logic       d2_mem_to_reg, d2_alu_src_imm, d2_active, d2_error;
    logic [2:0] d2_state;

    always #5 clk = ~clk;

    mips_cpu_control_fsm dut (
        .clk(clk), .reset(reset),
        .instr_opcode(instr_opcode), .instr_funct(instr_funct),
        .instr_rt(instr_rt), .instr_rd(instr_rd),
        .alu_zero(alu_zero), .pc_next_zero(pc_next_zero), .mem_waitrequest(mem_waitrequest),
        .mem_read(mem_read), .mem_write(mem_write), .addr_sel_pc(addr_sel_pc),
        .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
        .reg_write(reg_write), .write_register(write_register), .mem_to_reg(mem_to_reg),
        .alu_src_imm(alu_src_imm), .active(active), .error(error), .state(state)
    );

    mips_cpu_control_fsm #(.STALL_LIMIT(4), .CNT_W(8)) dut_lim (
        .clk(clk), .reset(reset),
        .instr_opcode(instr_opcode), .instr_funct(instr_funct),
        .instr_rt(instr_rt), .instr_rd(instr_rd),
        .alu_zero(alu_zero), .pc_next_zero(pc_next_zero), .mem_waitrequest(mem_waitrequest),
        .mem_read(d2_mem_read), .mem_write(d2_mem_write), .addr_sel_pc(d2_addr_sel_pc),
        .ir_write(d2_ir_write), .pc_write(d2_pc_write), .pc_src(d2_pc_src),
        .reg_write(d2_reg_write), .write_register(d2_write_register), .mem_to_reg(d2_mem_to_reg),
        .alu_src_imm(d2_alu_src_imm), .active(d2_active), .error(d2_error), .state(d2_state)
    );

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic        az;
        logic        pz;
        logic        wr;
        logic [19:0] exp;
    } vec_t;

    vec_t tbl[$];
    logic [5:0] cur_op, cur_fn;
    logic [4:0] cur_rt, cur_rd;
    int total = 0;
    int bad = 0;

    // {state, mem_read, mem_write, addr_sel_pc, ir_write, pc_write, pc_src,
    //  reg_write, write_register, mem_to_reg, alu_src_imm, active, error}
    function automatic logic [19:0] x(input logic [2:0] st, input logic mr, mw, asp, irw, pcw,
                                      input logic [1:0] pcs, input logic rw, input logic [4:0] wreg,
                                      input logic m2r, imm, act, err);
        return {st, mr, mw, asp, irw, pcw, pcs, rw, wreg, m2r, imm, act, err};
    endfunction

    task automatic ins(input logic [5:0] op, fn, input logic [4:0] rt, rd);
        cur_op = op; cur_fn = fn; cur_rt = rt; cur_rd = rd;
    endtask

    task automatic v(input logic rst, az, pz, wr, input logic [19:0] exp);
        vec_t e;
        e.rst = rst; e.op = cur_op; e.fn = cur_fn; e.rt = cur_rt; e.rd = cur_rd;
        e.az = az; e.pz = pz; e.wr = wr; e.exp = exp;
        tbl.push_back(e);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    logic [19:0] o_rst, o_f, o_fw, o_d, o_e, o_ei, o_h;

    initial begin
        o_rst = '0;
        o_f   = x(3'd0, 1, 0, 1, 1, 1, 2'd0, 0, 5'd0, 0, 0, 1, 0);
        o_fw  = x(3'd0, 1, 0, 1, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0);
        o_d   = x(3'd1, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0);
        o_e   = x(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0);
        o_ei  = x(3'd2, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 1, 1, 0);
        o_h   = x(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 0);

        // ADDIU rt=8
        ins(6'h09, 6'h00, 5'd8, 5'd0);
        v(1, 0, 0, 0, o_rst);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_ei);
        v(0, 0, 0, 0, x(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 5'd8, 0, 0, 1, 0));
        // LW rt=2, two fetch waits, three memory waits
        ins(6'h23, 6'h00, 5'd2, 5'd9);
        v(0, 0, 0, 1, o_fw); v(0, 0, 0, 1, o_fw);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_ei);
        for (int i = 0; i < 4; i++)
            v(0, 0, 0, (i < 3), x(3'd3, 1, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0));
        v(0, 0, 0, 0, x(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 5'd2, 1, 0, 1, 0));
        // R-type rd=0: WB without strobe
        ins(6'h00, 6'h21, 5'd5, 5'd0);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_e);
        v(0, 0, 0, 0, x(3'd4, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0));
        // R-type rd=17
        ins(6'h00, 6'h21, 5'd5, 5'd17);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_e);
        v(0, 0, 0, 0, x(3'd4, 0, 0, 0, 0, 0, 2'd0, 1, 5'd17, 0, 0, 1, 0));
        // BEQ not taken, then taken
        ins(6'h04, 6'h00, 5'd1, 5'd0);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d);
        v(0, 0, 0, 0, x(3'd2, 0, 0, 0, 0, 0, 2'd1, 0, 5'd0, 0, 0, 1, 0));
        v(0, 1, 0, 0, o_f); v(0, 1, 0, 0, o_d);
        v(0, 1, 0, 0, x(3'd2, 0, 0, 0, 0, 1, 2'd1, 0, 5'd0, 0, 0, 1, 0));
        // J
        ins(6'h02, 6'h00, 5'd0, 5'd0);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d);
        v(0, 0, 0, 0, x(3'd2, 0, 0, 0, 0, 1, 2'd2, 0, 5'd0, 0, 0, 1, 0));
        // JR to non-zero target
        ins(6'h00, 6'h08, 5'd0, 5'd0);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d);
        v(0, 0, 0, 0, x(3'd2, 0, 0, 0, 0, 1, 2'd3, 0, 5'd0, 0, 0, 1, 0));
        // SW no wait, then SW aborted by reset in MEM
        ins(6'h2B, 6'h00, 5'd3, 5'd0);
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_ei);
        v(0, 0, 0, 0, x(3'd3, 0, 1, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0));
        v(0, 0, 0, 0, o_f); v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_ei);
        v(0, 0, 0, 1, x(3'd3, 0, 1, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 1, 0));
        v(1, 0, 0, 1, o_rst);
        v(0, 0, 0, 0, o_f);
        // JR to zero: halt, no strobes, reset recovers
        ins(6'h00, 6'h08, 5'd0, 5'd0);
        v(0, 0, 1, 0, o_d);
        v(0, 0, 1, 0, x(3'd2, 0, 0, 0, 0, 1, 2'd3, 0, 5'd0, 0, 0, 1, 0));
        v(0, 0, 1, 0, o_h); v(0, 0, 1, 1, o_h);
        v(1, 0, 0, 0, o_rst);
        v(0, 0, 0, 0, o_f);
        // Opcode 0x3F
        ins(6'h3F, 6'h00, 5'd4, 5'd4);
        v(0, 0, 0, 0, o_d); v(0, 0, 0, 0, o_e);
`ifdef ILLEGAL_OPCODE_HALT_EN
        v(0, 0, 0, 0, x(3'd5, 0, 0, 0, 0, 0, 2'd0, 0, 5'd0, 0, 0, 0, 1));
        v(1, 0, 0, 0, o_rst);
`endif
        v(0, 0, 0, 0, o_f);

        @(negedge clk);
        foreach (tbl[i]) begin
            reset = tbl[i].rst; instr_opcode = tbl[i].op; instr_funct = tbl[i].fn;
            instr_rt = tbl[i].rt; instr_rd = tbl[i].rd; alu_zero = tbl[i].az;
            pc_next_zero = tbl[i].pz; mem_waitrequest = tbl[i].wr;
            #1;
            chk($sformatf("vec%0d", i),
                {12'd0, state, mem_read, mem_write, addr_sel_pc, ir_write, pc_write, pc_src,
                 reg_write, write_register, mem_to_reg, alu_src_imm, active, error},
                {12'd0, tbl[i].exp});
            @(negedge clk);
        end

        // Waitrequest stuck high in FETCH: limited instance halts, unlimited keeps waiting
        reset = 1'b1; mem_waitrequest = 1'b0; alu_zero = 1'b0; pc_next_zero = 1'b0;
        @(negedge clk);
        reset = 1'b0; mem_waitrequest = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk($sformatf("stall_fetch%0d", k), {d2_state, d2_mem_read, d2_error}, {3'd0, 1'b1, 1'b0});
            @(negedge clk);
        end
        #1;
        chk("stall_halt", {d2_state, d2_active, d2_mem_read, d2_error}, {3'd5, 1'b0, 1'b0, 1'b1});
        chk("stall_unlimited", {state, mem_read, error}, {3'd0, 1'b1, 1'b0});
        @(negedge clk);
        mem_waitrequest = 1'b0;
        #1;
        chk("stall_sticky", {d2_state, d2_error}, {3'd5, 1'b1});
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("stall_reset_out", {d2_state, d2_error, d2_active}, {3'd0, 1'b0, 1'b0});
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("stall_recover", {d2_state, d2_active, d2_error}, {3'd0, 1'b1, 1'b0});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
